// File: rtl/spio_spinnaker_link_packet_checker_pkg.sv
// Shared definitions for the link packet checker: packet field positions,
// FSM state type and the packet parity rule.
package spio_spinnaker_link_packet_checker_pkg;

  localparam int PKT_BITS         = 72;
  localparam int PARITY_BIT       = 0;
  localparam int PAYLOAD_FLAG_BIT = 1;
  localparam int KEY_LSB          = 8;
  localparam int KEY_MSB          = 39;
  localparam int PAYLOAD_LSB      = 40;
  localparam int PAYLOAD_MSB      = 71;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    TRACK = 2'd2
  } chk_state_t;

  // Odd parity over the header and key, plus the payload when the flag says it is present.
  function automatic logic pkt_parity_ok(input logic [PKT_BITS-1:0] pkt);
    if (pkt[PAYLOAD_FLAG_BIT]) return ^pkt;
    else                       return ^pkt[KEY_MSB:0];
  endfunction

endpackage

// File: rtl/spio_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with a parameterised reset seed.
module spio_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_out <= SEED;
    else     lfsr_out <= {lfsr_out[14:0],
                          lfsr_out[15] ^ lfsr_out[13] ^ lfsr_out[12] ^ lfsr_out[10]};
  end

endmodule

// File: rtl/spio_spinnaker_link_packet_checker.sv
// Self-checking packet sink: random backpressure, parity/sequence/payload
// checks, saturating error counters and a sticky error flag.
module spio_spinnaker_link_packet_checker
  import spio_spinnaker_link_packet_checker_pkg::*;
#(
  parameter int          CNT_BITS     = 16,
  parameter int unsigned STALL_THRESH = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_in,
  input  logic [PKT_BITS-1:0] packet_in,
  input  logic                fifo_write_in,
  output logic                fifo_full_out,
  output logic [31:0]         pkt_count_out,
  output logic [CNT_BITS-1:0] parity_err_out,
  output logic [CNT_BITS-1:0] seq_err_out,
  output logic [CNT_BITS-1:0] data_err_out,
  output logic [CNT_BITS-1:0] ovf_err_out,
  output logic                error_out,
  output logic                locked_out
);

  localparam logic [15:0]         THRESH  = 16'(STALL_THRESH);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  chk_state_t  state, state_nxt;
  logic [15:0] lfsr;
  logic [31:0] exp_key, key, payload;
  logic        take, par_ok, good, ovf_ev, par_ev, cnt_ev, seq_ev, data_ev;

  spio_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst      (reset),
    .lfsr_out (lfsr)
  );

  assign key     = packet_in[KEY_MSB:KEY_LSB];
  assign payload = packet_in[PAYLOAD_MSB:PAYLOAD_LSB];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable_in) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = SEEK;
        SEEK:    if (good) state_nxt = TRACK;
        TRACK:   state_nxt = TRACK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Writes landing while stalled are dropped before any other check.
  always_comb begin
    take       = enable_in && (state != IDLE) && fifo_write_in;
    par_ok     = pkt_parity_ok(packet_in);
    ovf_ev     = take && fifo_full_out;
    good       = take && !fifo_full_out && par_ok;
    par_ev     = take && !fifo_full_out && !par_ok;
    cnt_ev     = good || (par_ev && (state == TRACK));
    seq_ev     = good && (state == TRACK) && (key != exp_key);
    data_ev    = good && packet_in[PAYLOAD_FLAG_BIT] && (payload != ~key);
    locked_out = (state == TRACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_full_out  <= 1'b0;
      pkt_count_out  <= '0;
      parity_err_out <= '0;
      seq_err_out    <= '0;
      data_err_out   <= '0;
      ovf_err_out    <= '0;
      error_out      <= 1'b0;
      exp_key        <= '0;
    end else begin
      fifo_full_out <= (state != IDLE) && ((lfsr & 16'h00FF) < THRESH);
      // Both seeding and a resync leave the next expected key one past this one.
      if (!enable_in) exp_key <= '0;
      else if (good)  exp_key <= key + 32'd1;
      if (cnt_ev) pkt_count_out <= pkt_count_out + 32'd1;
      if (par_ev  && (parity_err_out != '1)) parity_err_out <= parity_err_out + CNT_ONE;
      if (seq_ev  && (seq_err_out    != '1)) seq_err_out    <= seq_err_out    + CNT_ONE;
      if (data_ev && (data_err_out   != '1)) data_err_out   <= data_err_out   + CNT_ONE;
      if (ovf_ev  && (ovf_err_out    != '1)) ovf_err_out    <= ovf_err_out    + CNT_ONE;
      if (ovf_ev || par_ev || seq_ev || data_ev) error_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spio_spinnaker_link_packet_checker.sv
// Bench for the link packet checker: two instances (no stall / 50% stall with
// narrow counters) compared every cycle against a behavioural model.
module tb_spio_spinnaker_link_packet_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en0 = 1'b0, wr0 = 1'b0, en1 = 1'b0, wr1 = 1'b0;
  logic [71:0] pk0 = '0, pk1 = '0;

  logic        full0, err0, lock0, full1, err1, lock1;
  logic [31:0] pc0, pc1;
  logic [15:0] pe0, se0, de0, oe0;
  logic [3:0]  pe1, se1, de1, oe1;

  int compared   = 0;
  int mismatched = 0;

  spio_spinnaker_link_packet_checker #(
    .CNT_BITS(16), .STALL_THRESH(0), .LFSR_SEED(16'hACE1)
  ) dut0 (
    .clk(clk), .reset(rst), .enable_in(en0), .packet_in(pk0), .fifo_write_in(wr0),
    .fifo_full_out(full0), .pkt_count_out(pc0), .parity_err_out(pe0), .seq_err_out(se0),
    .data_err_out(de0), .ovf_err_out(oe0), .error_out(err0), .locked_out(lock0)
  );

  spio_spinnaker_link_packet_checker #(
    .CNT_BITS(4), .STALL_THRESH(128), .LFSR_SEED(16'h5A5A)
  ) dut1 (
    .clk(clk), .reset(rst), .enable_in(en1), .packet_in(pk1), .fifo_write_in(wr1),
    .fifo_full_out(full1), .pkt_count_out(pc1), .parity_err_out(pe1), .seq_err_out(se1),
    .data_err_out(de1), .ovf_err_out(oe1), .error_out(err1), .locked_out(lock1)
  );

  // ---------------- behavioural model ----------------
  int          m_st[2];      // 0 disabled, 1 searching, 2 locked
  logic [31:0] m_exp[2], m_pc[2];
  logic [15:0] m_pe[2], m_se[2], m_de[2], m_oe[2], m_lfsr[2];
  logic        m_full[2], m_err[2];

  function automatic logic odd_parity(input logic [71:0] p);
    int unsigned ones = 0;
    int unsigned top  = p[1] ? 71 : 39;
    for (int unsigned b = 0; b <= top; b++) if (p[b]) ones++;
    return (ones % 2) == 1;
  endfunction

  function automatic logic [71:0] mk(input logic [31:0] key, input logic lng,
                                     input logic [31:0] pay, input logic good);
    logic [71:0] p;
    p        = '0;
    p[7:2]   = 6'($urandom);
    p[1]     = lng;
    p[39:8]  = key;
    p[71:40] = lng ? pay : $urandom;
    p[0]     = ~odd_parity(p);
    if (!good) p[0] = ~p[0];
    return p;
  endfunction

  task automatic model_reset(input int i);
    m_st[i] = 0; m_exp[i] = 0; m_pc[i] = 0;
    m_pe[i] = 0; m_se[i] = 0; m_de[i] = 0; m_oe[i] = 0;
    m_full[i] = 0; m_err[i] = 0;
    m_lfsr[i] = (i == 0) ? 16'hACE1 : 16'h5A5A;
  endtask

  task automatic model_step(input int i, input logic e, input logic w, input logic [71:0] p);
    int          st_old = m_st[i];
    logic [15:0] maxv   = (i == 0) ? 16'hFFFF : 16'h000F;
    int unsigned th     = (i == 0) ? 0 : 128;
    logic        full_new;
    logic [31:0] key    = p[39:8];
    full_new = (st_old != 0) && ((m_lfsr[i] % 256) < th);
    if (e && st_old != 0 && w) begin
      if (m_full[i]) begin
        if (m_oe[i] != maxv) m_oe[i]++;
        m_err[i] = 1;
      end else if (!odd_parity(p)) begin
        if (m_pe[i] != maxv) m_pe[i]++;
        m_err[i] = 1;
        if (st_old == 2) m_pc[i]++;
      end else begin
        m_pc[i]++;
        if (st_old == 2 && key != m_exp[i]) begin
          if (m_se[i] != maxv) m_se[i]++;
          m_err[i] = 1;
        end
        if (p[1] && p[71:40] != ~key) begin
          if (m_de[i] != maxv) m_de[i]++;
          m_err[i] = 1;
        end
        m_exp[i] = key + 1;
        m_st[i]  = 2;
      end
    end
    if (!e) begin m_st[i] = 0; m_exp[i] = 0; end
    else if (st_old == 0) m_st[i] = 1;
    m_full[i] = full_new;
    m_lfsr[i] = (m_lfsr[i] << 1) | 16'(^(m_lfsr[i] & 16'hB400));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, en0, wr0, pk0);
      model_step(1, en1, wr1, pk1);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("full0", 32'(full0), 32'(m_full[0]));
    check("pkt0",  pc0, m_pc[0]);
    check("par0",  32'(pe0), 32'(m_pe[0]));
    check("seq0",  32'(se0), 32'(m_se[0]));
    check("data0", 32'(de0), 32'(m_de[0]));
    check("ovf0",  32'(oe0), 32'(m_oe[0]));
    check("err0",  32'(err0), 32'(m_err[0]));
    check("lock0", 32'(lock0), 32'(m_st[0] == 2));
    check("full1", 32'(full1), 32'(m_full[1]));
    check("pkt1",  pc1, m_pc[1]);
    check("par1",  32'(pe1), 32'(m_pe[1]));
    check("seq1",  32'(se1), 32'(m_se[1]));
    check("data1", 32'(de1), 32'(m_de[1]));
    check("ovf1",  32'(oe1), 32'(m_oe[1]));
    check("err1",  32'(err1), 32'(m_err[1]));
    check("lock1", 32'(lock1), 32'(m_st[1] == 2));
  end

  // ---------------- stimulus ----------------
  task automatic send0(input logic [71:0] p);
    wr0 = 1'b1; pk0 = p;
    @(negedge clk);
    wr0 = 1'b0;
  endtask

  task automatic relock0();
    en0 = 1'b0;
    repeat (2) @(negedge clk);
    en0 = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pkt0", pc0, 32'd0);
    check("rst_lock0", 32'(lock0), 32'd0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_full1", 32'(full1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    fork
      begin : dut0_stream
        logic [31:0] k0, pay;
        logic        lng, good;
        en0 = 1'b1;
        @(negedge clk);
        // Clean sequential short packets.
        send0(mk(32'd5, 1'b0, 32'd0, 1'b1));
        check("t1_lock_after_first", 32'(lock0), 32'd1);
        for (int k = 6; k <= 8; k++) send0(mk(32'(k), 1'b0, 32'd0, 1'b1));
        check("t1_pkt", pc0, 32'd4);
        check("t1_seq", 32'(se0), 32'd0);
        check("t1_par", 32'(pe0), 32'd0);
        check("t1_err", 32'(err0), 32'd0);
        // One discontinuity, then resync.
        relock0();
        send0(mk(32'd10, 1'b0, 32'd0, 1'b1));
        send0(mk(32'd11, 1'b0, 32'd0, 1'b1));
        send0(mk(32'd20, 1'b0, 32'd0, 1'b1));
        send0(mk(32'd21, 1'b0, 32'd0, 1'b1));
        check("t2_seq", 32'(se0), 32'd1);
        check("t2_pkt", pc0, 32'd8);
        // Long packets: good payload then bad payload.
        relock0();
        send0(mk(32'h1234, 1'b1, 32'hFFFFEDCB, 1'b1));
        check("t3_data_good", 32'(de0), 32'd0);
        send0(mk(32'h1235, 1'b1, 32'h0, 1'b1));
        check("t3_data", 32'(de0), 32'd1);
        check("t3_seq", 32'(se0), 32'd1);
        check("t3_err", 32'(err0), 32'd1);
        // Bad parity while searching.
        relock0();
        send0(mk(32'd2, 1'b0, 32'd0, 1'b0));
        check("t4_par", 32'(pe0), 32'd1);
        check("t4_lock_low", 32'(lock0), 32'd0);
        send0(mk(32'd3, 1'b0, 32'd0, 1'b1));
        check("t4_lock_high", 32'(lock0), 32'd1);
        // Expected-key wrap.
        relock0();
        send0(mk(32'hFFFFFFFE, 1'b0, 32'd0, 1'b1));
        send0(mk(32'hFFFFFFFF, 1'b0, 32'd0, 1'b1));
        send0(mk(32'h0, 1'b0, 32'd0, 1'b1));
        send0(mk(32'h1, 1'b1, 32'hFFFFFFFE, 1'b1));
        check("t6_wrap_seq", 32'(se0), 32'd1);
        // Randomised traffic.
        k0 = $urandom;
        for (int n = 0; n < 1500; n++) begin
          if ($urandom_range(0, 99) < 3) relock0();
          if ($urandom_range(0, 99) < 10) k0 = $urandom;
          if ($urandom_range(0, 99) < 2)  k0 = 32'hFFFFFFFD;
          lng  = 1'($urandom_range(0, 1));
          pay  = ($urandom_range(0, 99) < 85) ? ~k0 : $urandom;
          good = ($urandom_range(0, 99) >= 8);
          send0(mk(k0, lng, pay, good));
          if (good) k0 = k0 + 1;
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
      end
      begin : dut1_stream
        logic [31:0] k1;
        int t, busy;
        en1 = 1'b1;
        @(negedge clk);
        t = 0;
        while (!full1 && t < 300) begin @(negedge clk); t++; end
        check("t5_stall_seen", 32'(full1), 32'd1);
        if (full1) begin
          wr1 = 1'b1; pk1 = mk(32'd7, 1'b0, 32'd0, 1'b1);
          @(negedge clk);
          wr1 = 1'b0;
          check("t5_ovf", 32'(oe1), 32'd1);
          check("t5_pkt", pc1, 32'd0);
        end
        k1 = 32'd100; busy = 0;
        for (int n = 0; n < 10000; n++) begin
          busy += int'(full1);
          wr1 = ($urandom_range(0, 99) < 40);
          if ($urandom_range(0, 99) < 10) k1 = $urandom;
          pk1 = mk(k1, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 99) < 85) ? ~k1 : $urandom,
                   $urandom_range(0, 99) >= 8);
          if (wr1 && !full1 && odd_parity(pk1)) k1 = k1 + 1;
          @(negedge clk);
        end
        wr1 = 1'b0;
        $display("stall duty: %0d / 10000 cycles", busy);
        check("t5_duty_in_band", 32'(busy >= 4500 && busy <= 5500), 32'd1);
        check("t5_ovf_saturated", 32'(oe1), 32'hF);
      end
    join

    // Reset in the middle of a stall.
    begin
      int t = 0;
      do begin @(posedge clk); #1; t++; end while (!full1 && t < 300);
      check("t6_pre_rst_stall", 32'(full1), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_full1", 32'(full1), 32'd0);
      check("t6_rst_pkt0", pc0, 32'd0);
      check("t6_rst_pkt1", pc1, 32'd0);
      check("t6_rst_seq0", 32'(se0), 32'd0);
      check("t6_rst_ovf1", 32'(oe1), 32'd0);
      check("t6_rst_err1", 32'(err1), 32'd0);
      check("t6_rst_lock0", 32'(lock0), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
